// File: rtl/agen_mem_buffer_pkg.sv
// Shared LSU types for the AGEN->LSU elastic buffer: memory packet, buffer entry, eligibility helper.
package agen_mem_buffer_pkg;

    localparam int unsigned AGEN_BUF_DEPTH = 4;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned TAG_W          = 6;

    typedef struct packed {
        logic       destValid;  // 1 = load, 0 = store
        logic       signExt;
        logic [1:0] size;
    } memFlags;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        memFlags           flags;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } memPkt;

    typedef struct packed {
        memPkt pkt;
        logic  isReserve;
    } agenBufEntry;

    // Stores always go; loads wait for a free MSHR.
    function automatic logic pktEligible(input logic isLoad, input logic mshrFull);
        return !(isLoad && mshrFull);
    endfunction

endpackage

// File: rtl/agen_mem_buffer_if.sv
// AGEN/LSU-side bundle of the memory buffer; master = AGEN/LSU environment, slave = buffer.
interface agen_mem_buffer_if #(
    parameter int unsigned DEPTH = agen_mem_buffer_pkg::AGEN_BUF_DEPTH
);
    import agen_mem_buffer_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             recoverFlag_i;
    memPkt            agenPacket_i;
    logic             agenIsReserve_i;
    logic             agenStall_o;
    logic             mshrFull_i;
    memPkt            memPacket_o;
    logic             ldIsReserve_o;
    logic [CNT_W-1:0] occupancy_o;
    logic             overflowErr_o;

    modport master (
        output recoverFlag_i, agenPacket_i, agenIsReserve_i, mshrFull_i,
        input  agenStall_o, memPacket_o, ldIsReserve_o, occupancy_o, overflowErr_o
    );

    modport slave (
        input  recoverFlag_i, agenPacket_i, agenIsReserve_i, mshrFull_i,
        output agenStall_o, memPacket_o, ldIsReserve_o, occupancy_o, overflowErr_o
    );

endinterface

// File: rtl/agen_buf_fifo.sv
// In-order storage for the AGEN buffer: entry array, wrapping head/tail, one-bit-wider count.
module agen_buf_fifo
    import agen_mem_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = AGEN_BUF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  agenBufEntry            wrEntry,
    output agenBufEntry            rdEntry,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    agenBufEntry      mem [DEPTH];

    // Pointer/count state; flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage is not reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail] <= wrEntry;
    end

    assign rdEntry = mem[head];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/agen_mem_buffer.sv
// Elastic buffer between AGEN and the LSU: in-order issue, MSHR load blocking, stall and overflow tracking.
// Optional same-cycle bypass of an idle buffer is enabled by defining AGEN_BUF_BYPASS_EN.
module agen_mem_buffer
    import agen_mem_buffer_pkg::*;
#(
    parameter int unsigned DEPTH        = AGEN_BUF_DEPTH,
    parameter int unsigned STALL_MARGIN = 1
) (
    input  logic              clk,
    input  logic              reset,
    agen_mem_buffer_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    agenBufEntry      headEntry;
    agenBufEntry      inEntry;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    logic             pop;
    logic             push;
    logic             bypass;
    logic             drop;
    logic [CNT_W-1:0] nextCount;
    memPkt            issuePkt;
    logic             issueReserve;

    logic             stallQ;
    logic             overflowQ;

    assign inEntry = '{pkt: bus.agenPacket_i, isReserve: bus.agenIsReserve_i};

    agen_buf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (bus.recoverFlag_i),
        .wrEntry (inEntry),
        .rdEntry (headEntry),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Issue selection, enqueue/drop decision and next occupancy.
    always_comb begin
        pop          = 1'b0;
        bypass       = 1'b0;
        push         = 1'b0;
        drop         = 1'b0;
        nextCount    = count;
        issuePkt     = '0;
        issueReserve = 1'b0;

        pop = reset && !bus.recoverFlag_i && !empty
              && pktEligible(headEntry.pkt.flags.destValid, bus.mshrFull_i);
`ifdef AGEN_BUF_BYPASS_EN
        bypass = reset && !bus.recoverFlag_i && empty && bus.agenPacket_i.valid
                 && pktEligible(bus.agenPacket_i.flags.destValid, bus.mshrFull_i);
`else
        bypass = 1'b0;
`endif
        push = bus.agenPacket_i.valid && !bus.recoverFlag_i && !bypass && (!full || pop);
        drop = bus.agenPacket_i.valid && !bus.recoverFlag_i && full && !pop;

        if (bus.recoverFlag_i) nextCount = '0;
        else                   nextCount = count + CNT_W'(push) - CNT_W'(pop);

        if (pop) begin
            issuePkt       = headEntry.pkt;
            issuePkt.valid = 1'b1;
            issueReserve   = headEntry.isReserve;
        end else if (bypass) begin
            issuePkt       = bus.agenPacket_i;
            issuePkt.valid = 1'b1;
            issueReserve   = bus.agenIsReserve_i;
        end
    end

    // Stall looks ahead at next-cycle occupancy; overflow is sticky until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallQ    <= 1'b0;
            overflowQ <= 1'b0;
        end else begin
            stallQ <= !bus.recoverFlag_i && (nextCount >= CNT_W'(DEPTH - STALL_MARGIN));
            if (drop) overflowQ <= 1'b1;
        end
    end

    assign bus.memPacket_o   = issuePkt;
    assign bus.ldIsReserve_o = issueReserve;
    assign bus.agenStall_o   = stallQ;
    assign bus.occupancy_o   = count;
    assign bus.overflowErr_o = overflowQ;

endmodule

// File: tb/tb_agen_mem_buffer.sv
// Self-checking bench for agen_mem_buffer (DEPTH=4, STALL_MARGIN=1); follows AGEN_BUF_BYPASS_EN if defined.
module tb_agen_mem_buffer;
    import agen_mem_buffer_pkg::*;

    logic clk = 1'b0;
    logic reset;

    agen_mem_buffer_if #(.DEPTH(4)) bus ();

    agen_mem_buffer #(.DEPTH(4), .STALL_MARGIN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        ld;
        logic        mf;
        logic        rec;
        logic        keep;
        logic        iss;
        int unsigned occ;
        logic        stall;
        logic        ovf;
    } vec_t;

    int          nChecks = 0;
    int          nPass   = 0;
    int          tagCnt  = 1;
    agenBufEntry sbQ[$];
    vec_t        tbl[13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(logic vld, logic ld, logic mf, logic rec, logic keep,
                                logic iss, int unsigned occ, logic stall, logic ovf);
        vec_t v;
        v.vld = vld; v.ld = ld; v.mf = mf; v.rec = rec; v.keep = keep;
        v.iss = iss; v.occ = occ; v.stall = stall; v.ovf = ovf;
        return v;
    endfunction

    // Present one AGEN packet; expected-accepted packets go to the scoreboard.
    task automatic drive(input logic vld, input logic ld, input logic mf, input logic rec, input logic keep);
        agenBufEntry e;
        e = '0;
        if (vld) begin
            e.pkt.valid           = 1'b1;
            e.pkt.tag             = TAG_W'(tagCnt);
            e.pkt.flags.destValid = ld;
            e.pkt.flags.size      = 2'($urandom_range(0, 3));
            e.pkt.address         = $urandom;
            e.pkt.data            = ld ? '0 : $urandom;
            e.isReserve           = ld & 1'($urandom_range(0, 1));
            tagCnt++;
        end
        bus.agenPacket_i    = e.pkt;
        bus.agenIsReserve_i = e.isReserve;
        bus.mshrFull_i      = mf;
        bus.recoverFlag_i   = rec;
        if (vld && keep && !rec) sbQ.push_back(e);
    endtask

    // Compare the issue strobe and, on issue, the packet against the scoreboard head.
    task automatic checkIssue(input string name, input logic expIss);
        agenBufEntry e;
        check({name, ".valid"}, 128'(bus.memPacket_o.valid), 128'(expIss));
        if (bus.memPacket_o.valid) begin
            if (sbQ.size() == 0) begin
                check({name, ".sbEmpty"}, 128'(1), 128'(0));
            end else begin
                e = sbQ.pop_front();
                check({name, ".pkt"}, 128'(bus.memPacket_o), 128'(e.pkt));
                check({name, ".rsv"}, 128'(bus.ldIsReserve_o), 128'(e.isReserve));
            end
        end
    endtask

    task automatic checkRegs(input string name, input int unsigned occ, input logic stall, input logic ovf);
        check({name, ".occ"},   128'(bus.occupancy_o),   128'(occ));
        check({name, ".stall"}, 128'(bus.agenStall_o),   128'(stall));
        check({name, ".ovf"},   128'(bus.overflowErr_o), 128'(ovf));
    endtask

    initial begin
        //           vld ld mf rec keep | iss occ stall ovf
        tbl[0]  = mk(1, 1, 1, 0, 1,   0, 1, 0, 0);  // load A blocked
        tbl[1]  = mk(1, 0, 1, 0, 1,   0, 2, 0, 0);  // store B behind A
        tbl[2]  = mk(0, 0, 0, 0, 0,   1, 1, 0, 0);  // A issues
        tbl[3]  = mk(0, 0, 0, 0, 0,   1, 0, 0, 0);  // B issues
        tbl[4]  = mk(1, 1, 1, 0, 1,   0, 1, 0, 0);
        tbl[5]  = mk(1, 1, 1, 0, 1,   0, 2, 0, 0);
        tbl[6]  = mk(1, 1, 1, 0, 1,   0, 3, 1, 0);  // stall after 3rd enqueue
        tbl[7]  = mk(1, 1, 1, 0, 1,   0, 4, 1, 0);
        tbl[8]  = mk(1, 1, 1, 0, 0,   0, 4, 1, 1);  // dropped -> overflow
        tbl[9]  = mk(1, 0, 0, 0, 1,   1, 4, 1, 1);  // full with dequeue
        tbl[10] = mk(0, 0, 0, 0, 0,   1, 3, 1, 1);
        tbl[11] = mk(1, 1, 0, 1, 0,   0, 0, 0, 1);  // recover at occupancy 3
        tbl[12] = mk(0, 0, 0, 0, 0,   0, 0, 0, 1);

        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst.valid", 128'(bus.memPacket_o.valid), 128'(0));
        check("rst.rsv",   128'(bus.ldIsReserve_o),     128'(0));
        checkRegs("rst", 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].vld, tbl[i].ld, tbl[i].mf, tbl[i].rec, tbl[i].keep);
            @(negedge clk);
            checkIssue($sformatf("vec%0d", i), tbl[i].iss);
            @(posedge clk); #1;
            checkRegs($sformatf("vec%0d", i), tbl[i].occ, tbl[i].stall, tbl[i].ovf);
            if (tbl[i].rec) sbQ.delete();
        end

        // Idle store: same-cycle with bypass, one cycle later without.
        drive(1, 0, 0, 0, 1);
        @(negedge clk);
`ifdef AGEN_BUF_BYPASS_EN
        checkIssue("idle.byp", 1'b1);
        @(posedge clk); #1;
        checkRegs("idle.byp", 0, 1'b0, 1'b1);
`else
        checkIssue("idle.q0", 1'b0);
        @(posedge clk); #1;
        checkRegs("idle.q0", 1, 1'b0, 1'b1);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checkIssue("idle.q1", 1'b1);
        @(posedge clk); #1;
        checkRegs("idle.q1", 0, 1'b0, 1'b1);
`endif

        // Ten push/pop pairs behind a held load keep occupancy at 1 across the pointer wrap.
        drive(1, 1, 1, 0, 1);
        @(negedge clk);
        checkIssue("wrap.ld", 1'b0);
        @(posedge clk); #1;
        checkRegs("wrap.ld", 1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 0, 1);
            @(negedge clk);
            checkIssue($sformatf("wrap%0d", i), 1'b1);
            @(posedge clk); #1;
            check($sformatf("wrap%0d.occ", i), 128'(bus.occupancy_o), 128'(1));
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checkIssue("wrap.drain", 1'b1);
        @(posedge clk); #1;
        check("wrap.occ", 128'(bus.occupancy_o), 128'(0));
        check("wrap.sbEmpty", 128'(sbQ.size()), 128'(0));

        // Asynchronous reset mid-stream clears everything immediately.
        drive(1, 1, 1, 0, 1);
        @(posedge clk); #1;
        drive(1, 1, 1, 0, 1);
        @(posedge clk); #1;
        check("mid.occ", 128'(bus.occupancy_o), 128'(2));
        drive(1, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        check("mid.valid", 128'(bus.memPacket_o.valid), 128'(0));
        check("mid.rsv",   128'(bus.ldIsReserve_o),     128'(0));
        checkRegs("mid", 0, 1'b0, 1'b0);
        sbQ.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checkIssue("post", 1'b0);
        checkRegs("post", 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
